// File: rtl/uart_tx_fifo_if.sv
// Bus-side store channel into the UART transmit FIFO.
// Master drives request/data/size flags; slave answers with ack/error pulses.
interface uart_tx_fifo_if;
    logic        wr_req;
    logic [31:0] wr_data;
    logic        byte_word;
    logic        half_word;
    logic        word;
    logic        wr_ack;
    logic        wr_error;

    modport master (
        output wr_req, wr_data, byte_word, half_word, word,
        input  wr_ack, wr_error
    );

    modport slave (
        input  wr_req, wr_data, byte_word, half_word, word,
        output wr_ack, wr_error
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with byte FIFO fed by 1/2/4-byte little-endian stores.
// Ports: clk, reset (async active-low), bus (uart_tx_fifo_if.slave),
//   tx (serial out, idles high), tx_busy, fifo_count (bytes queued).
// Option: define UART_TX_PARITY_EN to add an even-parity bit (8E1 framing).
module uart_tx_fifo #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    uart_tx_fifo_if.slave                 bus,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ack_q, err_q;

    state_t        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shreg_q;
    logic          tx_q, busy_q;

    logic [2:0]    n;
    logic          size_ok, open_req, room, push, bad, pop, baud_last;

    always_comb begin
        n       = 3'd0;
        size_ok = 1'b0;
        case ({bus.byte_word, bus.half_word, bus.word})
            3'b100:  begin n = 3'd1; size_ok = 1'b1; end
            3'b010:  begin n = 3'd2; size_ok = 1'b1; end
            3'b001:  begin n = 3'd4; size_ok = 1'b1; end
            default: begin n = 3'd0; size_ok = 1'b0; end
        endcase
    end

    // A response pulse in flight blocks re-evaluation of the same request.
    assign open_req  = bus.wr_req && !ack_q && !err_q;
    // Space check uses the count before any same-cycle pop.
    assign room      = ({1'b0, cnt_q} + (AW+2)'(n)) <= (AW+2)'(FIFO_DEPTH);
    assign push      = open_req && size_ok && room;
    assign bad       = open_req && !size_ok;
    assign pop       = (state_q == IDLE) && (cnt_q != '0);
    assign baud_last = (baud_q == BAUD_LAST);
    assign cnt_d     = cnt_q + (push ? (AW+1)'(n) : '0) - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push && (i < int'(n)))
                mem_q[wptr_q + AW'(i)] <= bus.wr_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (push)
                wptr_q <= wptr_q + AW'(n);
            if (pop)
                rptr_q <= rptr_q + AW'(1);
            cnt_q <= cnt_d;
            ack_q <= push;
            err_q <= bad;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        shreg_q <= mem_q[rptr_q];
                        state_q <= START;
                        baud_q  <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shreg_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= ^shreg_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= shreg_q[bit_q + 3'd1];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                PARITY: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_ack   = ack_q;
    assign bus.wr_error = err_q;
    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    assign fifo_count   = cnt_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a queue/timeline model,
// with a serial receiver and literal frame checks.
module tb_uart_tx_fifo;
    localparam int CD    = 4;
    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CD;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tx, tx_busy;
    logic [3:0] fifo_count;

    uart_tx_fifo_if bus();

    uart_tx_fifo #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .tx(tx), .tx_busy(tx_busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: byte queue plus the start cycle of the frame being sent.
    byte unsigned mq[$];
    bit           m_ack, m_err, fv;
    int           cyc, fs, mn;
    bit           ma, me, mp;
    logic [7:0]   fb;

    function automatic int size_of(input logic b, input logic h, input logic w);
        if (int'(b) + int'(h) + int'(w) != 1) return 0;
        return b ? 1 : (h ? 2 : 4);
    endfunction

    function automatic bit act(input int d);
        return fv && d >= fs && d < fs + FRAME;
    endfunction

    function automatic logic exp_tx(input int d);
        int bi;
        if (!act(d)) return 1'b1;
        bi = (d - fs) / CD;
        if (bi == 0) return 1'b0;
        if (bi <= 8) return fb[bi-1];
        if (NB == 11 && bi == 9) return ^fb;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_ack = 0; m_err = 0; fv = 0; cyc = 0;
        end else begin
            mn = size_of(bus.byte_word, bus.half_word, bus.word);
            ma = bus.wr_req && !m_ack && !m_err && mn != 0 && mq.size() + mn <= DEPTH;
            me = bus.wr_req && !m_ack && !m_err && mn == 0;
            mp = !act(cyc) && mq.size() > 0;
            if (mp) begin
                fb = mq.pop_front();
                fs = cyc + 1;
                fv = 1;
            end
            if (ma)
                for (int i = 0; i < mn; i++) mq.push_back(bus.wr_data[8*i +: 8]);
            m_ack = ma;
            m_err = me;
            cyc++;
        end
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("tx", tx, exp_tx(cyc));
            chk("tx_busy", tx_busy, act(cyc));
            chk("fifo_count", fifo_count, mq.size());
            chk("wr_ack", bus.wr_ack, m_ack);
            chk("wr_error", bus.wr_error, m_err);
        end
    end

    // Independent serial receiver sampling mid-bit.
    byte unsigned rxq[$];
    bit rx_en = 0;
    logic [7:0] rb;
    initial begin
        forever begin
            @(negedge clk);
            if (rx_en && reset && tx === 1'b0) begin
                repeat (2) @(negedge clk);
                chk("rx_start_mid", tx, 0);
                for (int j = 0; j < 8; j++) begin
                    repeat (CD) @(negedge clk);
                    rb[j] = tx;
                end
                if (NB == 11) begin
                    repeat (CD) @(negedge clk);
                    chk("rx_parity", tx, ^rb);
                end
                repeat (CD) @(negedge clk);
                chk("rx_stop", tx, 1);
                rxq.push_back(rb);
            end
        end
    end

    task automatic wr(input logic [31:0] d, input logic b, input logic h,
                      input logic w, output bit got_ack);
        bit done;
        bus.wr_data = d;
        bus.byte_word = b;
        bus.half_word = h;
        bus.word = w;
        bus.wr_req = 1'b1;
        got_ack = 0;
        done = 0;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge clk);
            if (bus.wr_ack || bus.wr_error) begin
                got_ack = bus.wr_ack;
                done = 1;
            end
        end
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL wr_timeout: got no response expected ack/error");
        end
        bus.wr_req = 1'b0;
        bus.byte_word = 1'b0;
        bus.half_word = 1'b0;
        bus.word = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int t;
        t = 0;
        while (rxq.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("rx_count", rxq.size(), n);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    bit           g;
    logic [10:0]  sym;
    int           kind, cnt0;
    logic [31:0]  d;

    initial begin
        bus.wr_req = 0; bus.wr_data = 0;
        bus.byte_word = 0; bus.half_word = 0; bus.word = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ack", bus.wr_ack, 0);
        cmp_en = 1;
        rx_en = 1;

        // Byte 0x55: literal frame shape.
        wr(32'h0000_0055, 1, 0, 0, g);
        chk("ack55", g, 1);
`ifdef UART_TX_PARITY_EN
        sym = {1'b1, 1'b0, 8'h55, 1'b0};
`else
        sym = {1'b1, 1'b1, 8'h55, 1'b0};
`endif
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            chk("frame55", tx, sym[i / CD]);
        end
        @(negedge clk);
        chk("idle_tx", tx, 1);
        chk("idle_busy", tx_busy, 0);
        wait_rx(1, 20);
        rxq.delete();

        // Word store unpacked little-endian.
        wr(32'h4433_2211, 0, 0, 1, g);
        chk("ack_word", g, 1);
        chk("word_count", fifo_count, 4);
        wait_rx(4, 4 * (FRAME + 2) + 20);
        for (int i = 0; i < 4; i++) chk("word_byte", rxq[i], 32'h11 * (i + 1));
        rxq.delete();

        // Three back-to-back words, third waits for space.
        wr(32'h0403_0201, 0, 0, 1, g);
        chk("ack_w1", g, 1);
        wr(32'h0807_0605, 0, 0, 1, g);
        chk("ack_w2", g, 1);
        wr(32'h0C0B_0A09, 0, 0, 1, g);
        chk("ack_w3", g, 1);
        wait_rx(12, 12 * (FRAME + 2) + 40);
        for (int i = 0; i < 12; i++) chk("bb_byte", rxq[i], i + 1);
        rxq.delete();

        // Invalid size flags.
        cnt0 = fifo_count;
        wr(32'h1234_5678, 0, 1, 1, g);
        chk("inv_no_ack", g, 0);
        chk("inv_err", bus.wr_error, 1);
        chk("inv_count", fifo_count, cnt0);
        @(negedge clk);
        chk("inv_err_pulse", bus.wr_error, 0);

        // Randomized traffic against the model.
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 5);
            d = $urandom;
            case (kind)
                0: wr(d, 1, 0, 0, g);
                1: wr(d, 0, 1, 0, g);
                2: wr(d, 0, 0, 1, g);
                3: wr(d, 0, 0, 0, g);
                4: wr(d, 1, 0, 1, g);
                default: wr(d, 1, 1, 1, g);
            endcase
            chk("rand_resp", g, kind <= 2);
            repeat ($urandom_range(0, CD * 12)) @(negedge clk);
        end
        for (int t = 0; t < 20000 && (mq.size() != 0 || act(cyc)); t++) @(negedge clk);
        chk("drain", mq.size(), 0);
        repeat (3) @(negedge clk);

        // Reset during third data bit.
        rx_en = 0;
        wr(32'hDEAD_BEEF, 0, 0, 1, g);
        chk("ack_rst", g, 1);
        repeat (13) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_tx", tx, 1);
        chk("async_count", fifo_count, 0);
        chk("async_busy", tx_busy, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            chk("post_rst_tx", tx, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
